// File: rtl/seg_adder_pipe.sv
// Pipelined segmented adder/subtractor: one SEG-bit slice per stage with registered carries.
// Operands are skewed through the stages so a new operation can enter every cycle.
module seg_adder_pipe #(
  parameter int WIDTH = 8,
  parameter int SEG   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTAGE = WIDTH / SEG;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_first;

  // The whole pipeline moves as one; a stalled output freezes every stage, bubbles included.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign c_first  = sub ? 1'b1 : cin;

  for (genvar gi = 0; gi < NSTAGE; gi++) begin : stg
    // Operand bits still to be consumed when entering this stage.
    localparam int RW = WIDTH - SEG * gi;

    logic [RW-1:0]          a_src;
    logic [RW-1:0]          b_src;
    logic                   c_src;
    logic                   v_src;
    logic [SEG:0]           seg_sum;
    logic [SEG*(gi+1)-1:0]  s_next;
    logic                   v_reg;
    logic                   c_reg;
    logic [SEG*(gi+1)-1:0]  s_reg;

    if (gi == 0) begin : head
      assign a_src  = a;
      assign b_src  = b_eff;
      assign c_src  = c_first;
      assign v_src  = in_valid;
      assign s_next = seg_sum[SEG-1:0];
    end else begin : body
      assign a_src  = stg[gi-1].fwd.a_reg;
      assign b_src  = stg[gi-1].fwd.b_reg;
      assign c_src  = stg[gi-1].c_reg;
      assign v_src  = stg[gi-1].v_reg;
      assign s_next = {seg_sum[SEG-1:0], stg[gi-1].s_reg};
    end

    assign seg_sum = {1'b0, a_src[SEG-1:0]} + {1'b0, b_src[SEG-1:0]} + {{SEG{1'b0}}, c_src};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_reg <= 1'b0;
        c_reg <= 1'b0;
        s_reg <= '0;
      end else if (adv) begin
        v_reg <= v_src;
        c_reg <= seg_sum[SEG];
        s_reg <= s_next;
      end
    end

    if (gi < NSTAGE - 1) begin : fwd
      // Unconsumed upper operand bits; the MSB rides along for the overflow test.
      logic [RW-SEG-1:0] a_reg;
      logic [RW-SEG-1:0] b_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (adv) begin
          a_reg <= a_src[RW-1:SEG];
          b_reg <= b_src[RW-1:SEG];
        end
      end
    end else begin : tail
      logic ovf_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_reg <= 1'b0;
        end else if (adv) begin
          ovf_reg <= (a_src[RW-1] == b_src[RW-1]) && (seg_sum[SEG-1] != a_src[RW-1]);
        end
      end
    end
  end

  assign out_valid = stg[NSTAGE-1].v_reg;
  assign sum       = stg[NSTAGE-1].s_reg;
  assign cout      = stg[NSTAGE-1].c_reg;
  assign ovf       = stg[NSTAGE-1].tail.ovf_reg;

endmodule

// File: tb/tb_seg_adder_pipe.sv
// Directed bench for seg_adder_pipe (WIDTH=8, SEG=2): single ops, stream with stall, bubbles, reset.
module tb_seg_adder_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       cin = 1'b0;
  logic       sub = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_adder_pipe #(.WIDTH(8), .SEG(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset/out_valid: got %b want 0", out_valid); end
    n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL reset/sum: got %h want 00", sum); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset/cout: got %b want 0", cout); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset/ovf: got %b want 0", ovf); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset/in_ready: got %b want 1", in_ready); end
    $display("reset: out_valid=%b sum=%h cout=%b ovf=%b in_ready=%b", out_valid, sum, cout, ovf, in_ready);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask

  // Single beat into an empty pipe; result must show after exactly 4 edges and last one cycle.
  task automatic run_op(input string name, input logic [7:0] va, input logic [7:0] vb,
                        input logic vcin, input logic vsub,
                        input logic [7:0] es, input logic ec, input logic eo);
    a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s/in_ready: got %b want 1", name, in_ready); end
    tick();
    in_valid = 1'b0; a = 8'hAA; b = 8'h55; cin = 1'b0; sub = 1'b0;
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s/early_valid: got %b want 0", name, out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s/out_valid: got %b want 1", name, out_valid); end
    n_checks++; if (sum !== es) begin n_fail++; $display("FAIL %s/sum: got %h want %h", name, sum, es); end
    n_checks++; if (cout !== ec) begin n_fail++; $display("FAIL %s/cout: got %b want %b", name, cout, ec); end
    n_checks++; if (ovf !== eo) begin n_fail++; $display("FAIL %s/ovf: got %b want %b", name, ovf, eo); end
    $display("%s: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b", name, va, vb, vcin, vsub, sum, cout, ovf);
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s/late_valid: got %b want 0", name, out_valid); end
  endtask

  task automatic test_basic_add();
    run_op("add_01_02", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
    run_op("add_10_20_cin", 8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0);
  endtask

  task automatic test_carry_ripple();
    run_op("ripple_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("ripple_fe_01_cin", 8'hFE, 8'h01, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_subtract_ovf();
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("ovf_add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("ovf_sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] held;
    logic [7:0] want;
    int  idx = 0;
    int  got = 0;
    int  stall_left = 0;
    int  zero_ready = 0;
    bit  seen_first = 0;
    bit  holding = 0;
    held = 8'h00;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      if (out_valid === 1'b1 && !seen_first) begin
        seen_first = 1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      in_valid  = (idx < 8);
      a = 8'(idx); b = 8'(idx); cin = 1'b0; sub = 1'b0;
      #1;
      if (in_ready !== 1'b1) zero_ready++;
      if (out_valid === 1'b1 && !out_ready) begin
        if (holding) begin
          n_checks++; if (sum !== held) begin n_fail++; $display("FAIL b2b/held_sum: got %h want %h", sum, held); end
        end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b/stall_in_ready: got %b want 0", in_ready); end
        held = sum;
        holding = 1;
        stall_left--;
      end else begin
        holding = 0;
      end
      if (out_valid === 1'b1 && out_ready) begin
        want = (exp_q.size() > 0) ? exp_q[0] : 8'hXX;
        n_checks++;
        if (exp_q.size() == 0 || sum !== want) begin
          n_fail++; $display("FAIL b2b/result%0d: got %h want %h", got, sum, want);
        end
        $display("b2b: result %0d sum=%h", got, sum);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        got++;
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(8'(2 * idx));
        idx++;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++; if (got != 8) begin n_fail++; $display("FAIL b2b/count: got %0d want 8", got); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b/leftover: got %0d want 0", exp_q.size()); end
    n_checks++; if (zero_ready != 3) begin n_fail++; $display("FAIL b2b/stall_cycles: got %0d want 3", zero_ready); end
  endtask

  task automatic test_bubbles();
    bit         hv[16];
    logic [7:0] exp_s[16];
    logic       exp_c[16];
    logic       expv;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      expv = (cyc >= 4) ? hv[cyc-4] : 1'b0;
      n_checks++; if (out_valid !== expv) begin n_fail++; $display("FAIL bubble/valid@%0d: got %b want %b", cyc, out_valid, expv); end
      if (expv && out_valid === 1'b1) begin
        n_checks++; if (sum !== exp_s[cyc-4]) begin n_fail++; $display("FAIL bubble/sum@%0d: got %h want %h", cyc, sum, exp_s[cyc-4]); end
        n_checks++; if (cout !== exp_c[cyc-4]) begin n_fail++; $display("FAIL bubble/cout@%0d: got %b want %b", cyc, cout, exp_c[cyc-4]); end
        $display("bubble: cycle %0d sum=%h cout=%b", cyc, sum, cout);
      end
      in_valid = (cyc < 8) && (cyc % 2 == 0);
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom_range(0, 1));
      sub = 1'b0;
      hv[cyc] = in_valid;
      {exp_c[cyc], exp_s[cyc]} = {1'b0, a} + {1'b0, b} + {8'h00, cin};
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a = (i == 0) ? 8'hF0 : 8'(8'h40 + i);
      b = (i == 0) ? 8'h20 : 8'h01;
      cin = 1'b0; sub = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || sum !== 8'h10 || cout !== 1'b1) begin
      n_fail++; $display("FAIL rstmid/pre: got valid=%b sum=%h cout=%b want 1 10 1", out_valid, sum, cout);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid/out_valid: got %b want 0", out_valid); end
    n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL rstmid/sum: got %h want 00", sum); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL rstmid/cout: got %b want 0", cout); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid/ovf: got %b want 0", ovf); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid/in_ready: got %b want 1", in_ready); end
    $display("rstmid: out_valid=%b sum=%h cout=%b ovf=%b", out_valid, sum, cout, ovf);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid/stale@%0d: got %b want 0", i, out_valid); end
      tick();
    end
    run_op("rstmid_new", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_ripple();
    test_subtract_ovf();
    test_back_to_back();
    test_bubbles();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_adder_pipe.md
# seg_adder_pipe

Parametrised, pipelined ripple-segment adder/subtractor that generalises the team's 2-bit combinational adder to WIDTH bits. It splits each operand into SEG-bit segments, adds one segment per pipeline stage, and registers the carry between stages. Operand and result segments are skewed so the block accepts one operation per cycle. A valid/ready handshake on both sides supports backpressure. It sits between a stimulus source and a checker/consumer in the datapath and is driven through the same interface/clocking-block bench style as the existing adder.

## Interface
- WIDTH, 8: operand/result width in bits; must be a multiple of SEG.
- SEG, 2: segment width per stage; NSTAGE = WIDTH/SEG, with NSTAGE ≥ 1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in; used only when sub=0.
- sub  in  1  0: a+b+cin; 1: a−b, computed as a+~b+1 with cin ignored.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB; when sub=1, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.

## Operation
- Stage k (0..NSTAGE−1) adds segment k of A and of B' (B' = sub ? ~b : b) plus the registered carry from stage k−1.
  - Stage 0 carry-in is sub ? 1 : cin.
- Each stage register holds:
  - a valid bit;
  - result segments 0..k already computed;
  - operand segments k+1..NSTAGE−1 not yet consumed;
  - the segment carry;
  - MSB operand sign bits, for ovf.
- ovf = (sign(A) == sign(B')) && (sign(sum) != sign(A)), where B' is the inverted B when sub=1.
- Global advance: adv = !out_valid || out_ready. in_ready = adv, combinational and with no dependence on in_valid.
- When adv=1, every stage shifts forward one position. Stage 0 loads valid = in_valid; a beat with in_valid=0 becomes a bubble.
- When adv=0, all stage registers hold, including sum/cout/ovf.
- Bubbles are not compressed. A stalled pipeline holds its bubbles in place.
- Outputs are driven directly from the last-stage register; there is no combinational path from a/b to sum.
- NSTAGE=1 degenerates to a single registered adder with the same handshake.

## Timing
- Latency: a beat accepted on edge t (in_valid && in_ready) appears with out_valid=1 after edge t+NSTAGE−1, provided no stall occurs in between. It is therefore visible during the cycle after edge t+NSTAGE−1.
- Each stall cycle (adv=0) adds exactly one cycle of latency to every in-flight beat.
- Throughput: 1 beat/cycle while out_ready=1.
- While out_valid=1 and out_ready=0:
  - sum, cout and ovf stay stable;
  - in_ready=0;
  - any input presented is not captured.
- A result is consumed on an edge where out_valid && out_ready.
- Simultaneous out_ready=1 and in_valid=1 on a full pipeline: one result is drained and one beat is accepted on the same edge, with no loss.
- Reset (rst_n=0, asynchronous, at any time including mid-stream):
  - all valid bits are cleared immediately;
  - out_valid=0, sum=0, cout=0, ovf=0;
  - in_ready=1 while rst_n=0, because out_valid=0.
  - In-flight beats are discarded, not flushed.
- Release of reset is synchronous to clk. The first acceptance can occur on the first rising edge with rst_n=1.

## Test plan
(All scenarios use WIDTH=8, SEG=2, NSTAGE=4.)
- Basic add: a=8'h01, b=8'h02, cin=0, sub=0, single beat -> after 4 edges, out_valid=1, sum=8'h03, cout=0, ovf=0; out_valid=0 on the following cycle.
- Full carry ripple across all segments: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Also a=8'hFE, b=8'h01, cin=1 -> sum=8'h00, cout=1.
- Subtract and overflow:
  - a=8'h05, b=8'h07, sub=1, cin=1 (ignored) -> sum=8'hFE, cout=0, ovf=0.
  - a=8'h7F, b=8'h01, sub=0 -> sum=8'h80, ovf=1.
  - a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, ovf=1.
- Back-to-back stream with backpressure: 8 consecutive beats a=i, b=i, i=0..7.
  - Hold out_ready=0 for 3 cycles after the first result.
  - Required: results 0,2,4,…,14 in order, none lost or duplicated.
  - The held output stays stable; in_ready=0 exactly during the stall.
- Bubbles: drive in_valid on alternate cycles with random operands -> results appear in the same alternating pattern after 4 cycles; every result matches a+b+cin mod 256.
- Reset mid-operation: assert rst_n=0 asynchronously (between edges) with 3 beats in flight.
  - Required: out_valid=0, sum=0, cout=0, ovf=0 immediately.
  - After release, no stale result appears, and a new beat 8'h10+8'h20 yields 8'h30 after 4 edges.
